audio_note_sequencer: RTL and testbench
=======================================

# audio_note_sequencer

Plays a programmed list of notes through the audio tone datapath without per-note processor intervention. Software fills a small note table (period, duration) through the AXI4-Lite register file and pulses start. The sequencer hands each period to the tone generator over a valid/ready handshake, holds it for the programmed duration, and inserts an optional inter-note gap. It sits between the Audio_Controller register file and the tone generator, in the ACLK domain.

## Interface
Parameters:
- NOTE_DEPTH, 16: note table entries; power of two, ≥2.
- PERIOD_W, 20: tone half-period width, in ACLK cycles.
- DUR_W, 24: note duration width, in ACLK cycles.
- GAP_CYCLES, 0: silent cycles inserted after every note; 0 means no gap.

Ports:
- ACLK  in  1  sole clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- cfg_wr_en  in  1  table write strobe, one entry per cycle.
- cfg_wr_addr  in  $clog2(NOTE_DEPTH)  table entry index.
- cfg_period  in  PERIOD_W  period for the entry; 0 means rest.
- cfg_duration  in  DUR_W  duration for the entry; 0 means skip the entry.
- num_notes  in  $clog2(NOTE_DEPTH)+1  notes to play, taken from entry 0 upward; sampled at start.
- loop  in  1  level; when high, index 0 follows the last note.
- start  in  1  pulse; ignored while busy.
- stop  in  1  pulse; aborts playback.
- tone_period  out  PERIOD_W  period offered to the tone generator.
- tone_valid  out  1  tone_period is valid.
- tone_ready  in  1  tone generator accepts tone_period.
- tone_en  out  1  tone generator output enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a non-looping sequence ends.
- note_idx  out  $clog2(NOTE_DEPTH)  index of the current entry.

## Operation
- States: IDLE, LOAD, PLAY, GAP.
- IDLE:
  - start with num_notes>0: latch num_notes, note_idx←0, go to LOAD.
  - start with num_notes=0: pulse done next cycle, stay in IDLE.
- LOAD:
  - If the entry's duration is 0: skip it. Advance the index without asserting tone_valid, spending 1 cycle per skipped entry.
  - Otherwise assert tone_valid with tone_period = entry period.
  - On tone_valid&&tone_ready: load the duration counter, go to PLAY.
  - If period=0 (rest): no handshake; go directly to PLAY.
- PLAY:
  - tone_en=1 unless the entry is a rest.
  - Counter decrements each cycle; leave PLAY after exactly `duration` cycles.
  - Exit to GAP if GAP_CYCLES>0, else to the advance step.
- GAP: tone_en=0 for GAP_CYCLES cycles, then advance.
- Advance:
  - If note_idx = latched_num-1: with loop=1, go to index 0 and LOAD; with loop=0, pulse done and go to IDLE.
  - Otherwise note_idx+1 and LOAD.
  - loop is sampled at advance time.
- num_notes > NOTE_DEPTH is clamped to NOTE_DEPTH.
- stop in any state:
  - Next cycle: IDLE, tone_en=0, tone_valid=0, no done pulse.
  - stop and start in the same cycle: stop wins.
- Table writes during playback are permitted. They affect an entry the next time it is fetched in LOAD, and never the note in PLAY.
- A simultaneous read and write of the same entry in LOAD returns the old value.

## Timing
- Reset values:
  - All outputs 0; state IDLE; note_idx 0.
  - Table contents cleared to 0.
- start sampled on edge N → LOAD, busy=1, and tone_valid=1 at N+1.
- Handshake on edge M → PLAY, tone_en=1 at M+1, held for exactly `duration` cycles.
- tone_period and tone_valid stay stable until accepted. tone_valid never drops without a handshake, except on stop.
- done is asserted in the cycle after the last PLAY/GAP cycle; busy=0 in that same cycle.
- ARESETN asserted mid-note: all outputs go to 0 immediately (asynchronous).

## Structure
- Package audio_seq_pkg holds:
  - the state enum seq_state_t (IDLE, LOAD, PLAY, GAP);
  - the default width constants;
  - the note entry struct note_t {period, duration}.
- Sub-module audio_note_table: NOTE_DEPTH×note_t storage with a synchronous write port and an asynchronous read port, cleared on reset.
- The top level contains the FSM, duration counter, gap counter and index counter.

## Test plan
- Three notes (100/10, 200/5, 0/4), tone_ready tied high, GAP_CYCLES=0 → tone_en high 10 cycles (period 100), then 5 cycles (period 200), then 4 low; done 1 cycle later.
- tone_ready held low for 7 cycles → tone_valid=1 and tone_period=100 stable throughout; PLAY starts only after ready.
- Entry 1 duration 0 with num_notes=3 → entry 1 never reaches tone_valid; note_idx goes 0→1→2.
- loop=1 with two notes → index wraps 1→0 with no done pulse; stop mid-PLAY → tone_en=0 next cycle, busy=0, no done.
- start with num_notes=0 → done pulse, busy stays 0; start while busy → ignored, sequence unchanged.
- ARESETN pulsed low mid-PLAY → all outputs 0 at once; a subsequent start plays zeroed entries as skips and returns done.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// Shared types and default widths for the audio note sequencer.
// Imported by the note table and the sequencer top level.
package audio_seq_pkg;

    localparam int NOTE_DEPTH_DEF = 16;
    localparam int PERIOD_W_DEF   = 20;
    localparam int DUR_W_DEF      = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } seq_state_t;

    typedef struct packed {
        logic [PERIOD_W_DEF-1:0] period;
        logic [DUR_W_DEF-1:0]    duration;
    } note_t;

endpackage

// File: rtl/audio_note_table.sv
// Note table: synchronous write, asynchronous read, cleared on reset.
// A read of an entry being written in the same cycle sees the old value.
module audio_note_table
    import audio_seq_pkg::*;
#(
    parameter int NOTE_DEPTH = NOTE_DEPTH_DEF,
    parameter int AW         = $clog2(NOTE_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  note_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output note_t         rd_data
);

    note_t mem_q [NOTE_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOTE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/audio_note_sequencer.sv
// Plays a programmed list of (period, duration) notes into the tone generator.
// The fetched entry is latched on entry to LOAD so later table writes never disturb it.
module audio_note_sequencer
    import audio_seq_pkg::*;
#(
    parameter int NOTE_DEPTH = NOTE_DEPTH_DEF,
    parameter int PERIOD_W   = PERIOD_W_DEF,
    parameter int DUR_W      = DUR_W_DEF,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          cfg_wr_en,
    input  logic [$clog2(NOTE_DEPTH)-1:0] cfg_wr_addr,
    input  logic [PERIOD_W-1:0]           cfg_period,
    input  logic [DUR_W-1:0]              cfg_duration,
    input  logic [$clog2(NOTE_DEPTH):0]   num_notes,
    input  logic                          loop,
    input  logic                          start,
    input  logic                          stop,
    output logic [PERIOD_W-1:0]           tone_period,
    output logic                          tone_valid,
    input  logic                          tone_ready,
    output logic                          tone_en,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(NOTE_DEPTH)-1:0] note_idx
);

    localparam int AW = $clog2(NOTE_DEPTH);
    localparam int NW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    seq_state_t          state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [NW-1:0]       num_q, num_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                done_q, done_d;
    logic                fetch;
    logic                adv;
    logic                last;
    note_t               wr_note;
    note_t               rd_note;

    always_comb begin
        wr_note          = '0;
        wr_note.period   = PERIOD_W_DEF'(cfg_period);
        wr_note.duration = DUR_W_DEF'(cfg_duration);
    end

    audio_note_table #(
        .NOTE_DEPTH(NOTE_DEPTH),
        .AW        (AW)
    ) u_table (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .wr_en  (cfg_wr_en),
        .wr_addr(cfg_wr_addr),
        .wr_data(wr_note),
        .rd_addr(idx_d),
        .rd_data(rd_note)
    );

    assign last = ({1'b0, idx_q} == (num_q - 1'b1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        num_d     = num_q;
        dur_cnt_d = dur_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        fetch     = 1'b0;
        adv       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_notes == '0) begin
                        done_d = 1'b1;
                    end else begin
                        num_d   = (num_notes > NW'(NOTE_DEPTH)) ?
                                  NW'(NOTE_DEPTH) : num_notes;
                        idx_d   = '0;
                        fetch   = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (dur_q == '0) begin
                    adv = 1'b1;
                end else if (per_q == '0 || tone_ready) begin
                    dur_cnt_d = dur_q;
                    state_d   = PLAY;
                end
            end
            PLAY: begin
                if (dur_cnt_q == DUR_W'(1)) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = GW'(GAP_CYCLES);
                        state_d   = GAP;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    dur_cnt_d = dur_cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(1)) begin
                    adv = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
        endcase
        if (adv) begin
            if (!last) begin
                idx_d   = idx_q + 1'b1;
                fetch   = 1'b1;
                state_d = LOAD;
            end else if (loop) begin
                idx_d   = '0;
                fetch   = 1'b1;
                state_d = LOAD;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
        // stop overrides everything, including a same-cycle start
        if (stop) begin
            state_d = IDLE;
            done_d  = 1'b0;
            fetch   = 1'b0;
        end
    end

    always_comb begin
        per_d = per_q;
        dur_d = dur_q;
        if (fetch) begin
            per_d = rd_note.period[PERIOD_W-1:0];
            dur_d = rd_note.duration[DUR_W-1:0];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            num_q     <= '0;
            per_q     <= '0;
            dur_q     <= '0;
            dur_cnt_q <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            per_q     <= per_d;
            dur_q     <= dur_d;
            dur_cnt_q <= dur_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    assign tone_period = per_q;
    assign tone_valid  = (state_q == LOAD) && (dur_q != '0) && (per_q != '0);
    assign tone_en     = (state_q == PLAY) && (per_q != '0);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign note_idx    = idx_q;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Directed bench for audio_note_sequencer: playback, backpressure, skips,
// looping, stop, start corner cases and asynchronous reset.
module tb_audio_note_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr_en;
    logic [3:0]  cfg_wr_addr;
    logic [19:0] cfg_period;
    logic [23:0] cfg_duration;
    logic [4:0]  num_notes;
    logic        loop;
    logic        start;
    logic        stop;
    logic [19:0] tone_period;
    logic        tone_valid;
    logic        tone_ready;
    logic        tone_en;
    logic        busy;
    logic        done;
    logic [3:0]  note_idx;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;
    int maxidx;
    int vseen;

    always #5 clk = ~clk;

    audio_note_sequencer dut (
        .ACLK        (clk),
        .ARESETN     (rst_n),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_addr (cfg_wr_addr),
        .cfg_period  (cfg_period),
        .cfg_duration(cfg_duration),
        .num_notes   (num_notes),
        .loop        (loop),
        .start       (start),
        .stop        (stop),
        .tone_period (tone_period),
        .tone_valid  (tone_valid),
        .tone_ready  (tone_ready),
        .tone_en     (tone_en),
        .busy        (busy),
        .done        (done),
        .note_idx    (note_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [19:0] p,
                      input logic [23:0] d);
        cfg_wr_en    = 1'b1;
        cfg_wr_addr  = a;
        cfg_period   = p;
        cfg_duration = d;
        tick();
        cfg_wr_en    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic count_en();
        cnt = 0;
        while (tone_en && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        cfg_wr_en    = 1'b0;
        cfg_wr_addr  = '0;
        cfg_period   = '0;
        cfg_duration = '0;
        num_notes    = '0;
        loop         = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        tone_ready   = 1'b1;
        tick();
        tick();
        chk("rst_outs", {tone_valid, tone_en, busy, done}, 0);
        chk("rst_idx", note_idx, 0);
        chk("rst_per", tone_period, 0);
        rst_n = 1'b1;
        tick();

        // three notes, ready high
        wr(0, 100, 10);
        wr(1, 200, 5);
        wr(2, 0, 4);
        num_notes = 3;
        pulse_start();
        chk("t1_load_busy", busy, 1);
        chk("t1_load_valid", tone_valid, 1);
        chk("t1_load_per", tone_period, 100);
        tick();
        count_en();
        chk("t1_n0_len", cnt, 10);
        chk("t1_n1_valid", tone_valid, 1);
        chk("t1_n1_per", tone_period, 200);
        tick();
        count_en();
        chk("t1_n1_len", cnt, 5);
        chk("t1_rest_valid", tone_valid, 0);
        chk("t1_rest_idx", note_idx, 2);
        tick();
        cnt = 0;
        while (busy && cnt < 100) begin
            chk("t1_rest_en", tone_en, 0);
            cnt++;
            tick();
        end
        chk("t1_rest_len", cnt, 4);
        chk("t1_done", done, 1);
        tick();
        chk("t1_done_clr", done, 0);

        // backpressure: ready low for 7 cycles
        tone_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            chk("t2_hold", {tone_en, tone_valid, 12'd0, tone_period},
                {1'b0, 1'b1, 12'd0, 20'd100});
            tick();
        end
        tone_ready = 1'b1;
        chk("t2_still_load", {tone_en, tone_valid}, 2'b01);
        tick();
        chk("t2_play", tone_en, 1);
        pulse_stop();
        chk("t2_stop", {tone_en, tone_valid, busy, done}, 0);
        tick();
        chk("t2_no_done", done, 0);

        // skipped entry 1
        wr(1, 300, 0);
        pulse_start();
        chk("t3_idx0", note_idx, 0);
        tick();
        count_en();
        chk("t3_n0_len", cnt, 10);
        chk("t3_idx1", note_idx, 1);
        chk("t3_skip_valid", tone_valid, 0);
        tick();
        chk("t3_idx2", note_idx, 2);
        chk("t3_rest_valid", tone_valid, 0);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
        chk("t3_done", done, 1);
        tick();

        // looping over two notes, then stop
        wr(1, 200, 5);
        num_notes = 2;
        loop = 1'b1;
        pulse_start();
        tick();
        count_en();
        chk("t4_n0_len", cnt, 10);
        tick();
        count_en();
        chk("t4_n1_len", cnt, 5);
        chk("t4_wrap_idx", note_idx, 0);
        chk("t4_wrap_state", {busy, done, tone_valid}, 3'b101);
        chk("t4_wrap_per", tone_period, 100);
        tick();
        tick();
        chk("t4_play", tone_en, 1);
        pulse_stop();
        chk("t4_stop", {tone_en, busy, done}, 0);
        tick();
        chk("t4_no_done", done, 0);
        loop = 1'b0;

        // zero-length start, then start while busy
        num_notes = 0;
        pulse_start();
        chk("t5_zero_done", {busy, done}, 2'b01);
        tick();
        chk("t5_zero_clr", done, 0);
        num_notes = 2;
        pulse_start();
        tick();
        num_notes = 3;
        pulse_start();
        chk("t5_ignored", {note_idx, 3'b0, tone_en}, 8'h01);
        maxidx = 0;
        cnt = 0;
        while (busy && cnt < 100) begin
            if (int'(note_idx) > maxidx) maxidx = int'(note_idx);
            cnt++;
            tick();
        end
        chk("t5_maxidx", maxidx, 1);
        chk("t5_done", done, 1);
        tick();

        // asynchronous reset mid-PLAY
        num_notes = 2;
        pulse_start();
        tick();
        tick();
        chk("t6_pre", tone_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", {tone_valid, tone_en, busy, done}, 0);
        chk("t6_async_per", tone_period, 0);
        chk("t6_async_idx", note_idx, 0);
        tick();
        rst_n = 1'b1;
        tick();
        num_notes = 3;
        pulse_start();
        cnt = 0;
        vseen = 0;
        while (busy && cnt < 100) begin
            if (tone_valid || tone_en) vseen++;
            cnt++;
            tick();
        end
        chk("t6_skip_len", cnt, 3);
        chk("t6_no_valid", vseen, 0);
        chk("t6_done", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
